// File: rtl/shift_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : shift_seq_pkg
// Purpose  : Shared types and constants for the shift sequencer: the
//            controller state encoding and the command direction values.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package shift_seq_pkg;

    // Controller states, in the order a command walks through them.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        SHIFT   = 3'd2,
        CAPTURE = 3'd3,
        RESP    = 3'd4
    } state_t;

    // Command direction encoding carried on cmd_dir.
    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

endpackage : shift_seq_pkg
`default_nettype wire

// File: rtl/shift_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : shift_sequencer
// Purpose  : Command-driven controller for an attached 8-bit universal shift
//            register. Accepts a (data, direction, count) command, loads the
//            data into the register, issues exactly `count` single-place
//            shift pulses, then captures the register output into a response
//            held until the consumer accepts it.
// Ports    : clk, reset            - clock, async active-high reset
//            cmd_valid/cmd_ready   - command handshake
//            cmd_dir/count/data    - command fields (dir 0=left, 1=right)
//            sr_shift_left/right   - register shift controls (never both high)
//            sr_parallel_in        - register load value (latched cmd data)
//            sr_parallel_out       - register contents
//            rsp_valid/rsp_ready   - response handshake
//            rsp_data              - captured shifted value
//            busy                  - high whenever not idle
// Revision : 1.0 - initial release
// ============================================================================
module shift_sequencer
    import shift_seq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_dir,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic [WIDTH-1:0] cmd_data,
    output logic             sr_shift_left,
    output logic             sr_shift_right,
    output logic [WIDTH-1:0] sr_parallel_in,
    input  logic [WIDTH-1:0] sr_parallel_out,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             busy
);

    localparam logic [CNT_W-1:0] c_cnt_one  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] c_cnt_zero = '0;

    state_t             r_state;
    state_t             w_next_state;
    logic               r_dir;
    logic [CNT_W-1:0]   r_remaining;
    logic [WIDTH-1:0]   r_data;
    logic [WIDTH-1:0]   r_rsp_data;
    logic               r_rsp_valid;

    // ------------------------------------------------------------------
    // State register plus the datapath registers that move with it.
    // r_remaining holds the command count from accept and counts down
    // once per SHIFT cycle; the last shift happens when it reads 1.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_dir       <= DIR_LEFT;
            r_remaining <= '0;
            r_data      <= '0;
            r_rsp_data  <= '0;
            r_rsp_valid <= 1'b0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                IDLE: begin
                    if (cmd_valid) begin
                        r_dir       <= cmd_dir;
                        r_remaining <= cmd_count;
                        r_data      <= cmd_data;
                    end
                end
                SHIFT: begin
                    r_remaining <= r_remaining - c_cnt_one;
                end
                CAPTURE: begin
                    // Samples the register before the reload it performs
                    // at this same edge (both controls are low here).
                    r_rsp_data  <= sr_parallel_out;
                    r_rsp_valid <= 1'b1;
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic.
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (cmd_valid) begin
                    w_next_state = LOAD;
                end
            end
            LOAD: begin
                if (r_remaining != c_cnt_zero) begin
                    w_next_state = SHIFT;
                end else begin
                    w_next_state = CAPTURE;
                end
            end
            SHIFT: begin
                if (r_remaining == c_cnt_one) begin
                    w_next_state = CAPTURE;
                end
            end
            CAPTURE: begin
                w_next_state = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs. Shift controls are only active in SHIFT and the direction
    // bit selects exactly one, so both can never be high together.
    // cmd_ready is gated by reset so it reads 0 while reset is held and
    // rises as soon as reset is released.
    // ------------------------------------------------------------------
    always_comb begin
        cmd_ready      = (r_state == IDLE) && !reset;
        busy           = (r_state != IDLE);
        sr_shift_left  = (r_state == SHIFT) && (r_dir == DIR_LEFT);
        sr_shift_right = (r_state == SHIFT) && (r_dir == DIR_RIGHT);
        sr_parallel_in = r_data;
        rsp_valid      = r_rsp_valid;
        rsp_data       = r_rsp_data;
    end

endmodule : shift_sequencer
`default_nettype wire

// File: tb/tb_shift_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_shift_sequencer
// Purpose  : Self-checking bench for shift_sequencer. Models the attached
//            8-bit universal shift register locally, applies a table of
//            commands with hand-computed results, then runs response-stall
//            and mid-operation reset sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_shift_sequencer;

    localparam int WIDTH = 8;
    localparam int CNT_W = 3;

    logic             clk;
    logic             reset;
    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_dir;
    logic [CNT_W-1:0] cmd_count;
    logic [WIDTH-1:0] cmd_data;
    logic             sr_shift_left;
    logic             sr_shift_right;
    logic [WIDTH-1:0] sr_parallel_in;
    logic [WIDTH-1:0] sr_parallel_out;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic             busy;

    int n_checks = 0;
    int n_fail   = 0;

    shift_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk             (clk),
        .reset           (reset),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_dir         (cmd_dir),
        .cmd_count       (cmd_count),
        .cmd_data        (cmd_data),
        .sr_shift_left   (sr_shift_left),
        .sr_shift_right  (sr_shift_right),
        .sr_parallel_in  (sr_parallel_in),
        .sr_parallel_out (sr_parallel_out),
        .rsp_valid       (rsp_valid),
        .rsp_ready       (rsp_ready),
        .rsp_data        (rsp_data),
        .busy            (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Universal shift register model: load when both controls low,
    // single-place zero-fill shift otherwise.
    logic [WIDTH-1:0] sr_q;
    always @(posedge clk) begin
        if (!sr_shift_left && !sr_shift_right)
            sr_q <= sr_parallel_in;
        else if (sr_shift_left && !sr_shift_right)
            sr_q <= {sr_q[WIDTH-2:0], 1'b0};
        else if (sr_shift_right && !sr_shift_left)
            sr_q <= {1'b0, sr_q[WIDTH-1:1]};
    end
    assign sr_parallel_out = sr_q;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Called just after the command-accept edge. Counts edges until
    // rsp_valid is seen and tallies shift pulses in every cycle before it.
    task automatic wait_rsp(output int cyc, output int lp, output int rp, output int both);
        cyc = 0; lp = 0; rp = 0; both = 0;
        while (!rsp_valid && cyc < 20) begin
            if (sr_shift_left)  lp++;
            if (sr_shift_right) rp++;
            if (sr_shift_left && sr_shift_right) both++;
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic do_cmd(input logic dir, input logic [CNT_W-1:0] cnt,
                          input logic [WIDTH-1:0] data, input logic [WIDTH-1:0] exp,
                          input int idx);
        int cyc, lp, rp, both;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_dir = dir; cmd_count = cnt; cmd_data = data;
        check($sformatf("v%0d cmd_ready", idx), {31'd0, cmd_ready}, 32'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        check($sformatf("v%0d busy", idx), {31'd0, busy}, 32'd1);
        wait_rsp(cyc, lp, rp, both);
        check($sformatf("v%0d latency", idx), cyc, 32'(cnt) + 32'd2);
        check($sformatf("v%0d rsp_data", idx), {24'd0, rsp_data}, {24'd0, exp});
        check($sformatf("v%0d left pulses", idx), lp, (dir == 1'b0) ? 32'(cnt) : 32'd0);
        check($sformatf("v%0d right pulses", idx), rp, (dir == 1'b1) ? 32'(cnt) : 32'd0);
        check($sformatf("v%0d both high", idx), both, 32'd0);
        @(posedge clk); #1;
        check($sformatf("v%0d rsp_valid clear", idx), {31'd0, rsp_valid}, 32'd0);
        check($sformatf("v%0d cmd_ready back", idx), {31'd0, cmd_ready}, 32'd1);
        check($sformatf("v%0d parallel_in", idx), {24'd0, sr_parallel_in}, {24'd0, data});
    endtask

    typedef struct {
        logic             dir;
        logic [CNT_W-1:0] cnt;
        logic [WIDTH-1:0] data;
        logic [WIDTH-1:0] exp;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int cyc, lp, rp, both;
        bit saw_valid;

        vecs[0] = '{dir: 1'b0, cnt: 3'd1, data: 8'he5, exp: 8'hca};
        vecs[1] = '{dir: 1'b1, cnt: 3'd2, data: 8'he5, exp: 8'h39};
        vecs[2] = '{dir: 1'b0, cnt: 3'd3, data: 8'he5, exp: 8'h28};
        vecs[3] = '{dir: 1'b0, cnt: 3'd0, data: 8'he5, exp: 8'he5};
        vecs[4] = '{dir: 1'b1, cnt: 3'd7, data: 8'he5, exp: 8'h01};
        vecs[5] = '{dir: 1'b0, cnt: 3'd7, data: 8'h5b, exp: 8'h80};
        vecs[6] = '{dir: 1'b1, cnt: 3'd4, data: 8'hb6, exp: 8'h0b};

        reset = 1'b0; cmd_valid = 1'b0; cmd_dir = 1'b0; cmd_count = '0;
        cmd_data = '0; rsp_ready = 1'b1;
        #2 reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset cmd_ready", {31'd0, cmd_ready}, 32'd0);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("reset outs", {14'd0, sr_shift_left, sr_shift_right, sr_parallel_in, rsp_data}, 32'd0);
        reset = 1'b0;
        #1;
        check("release cmd_ready", {31'd0, cmd_ready}, 32'd1);

        for (int i = 0; i < 7; i++)
            do_cmd(vecs[i].dir, vecs[i].cnt, vecs[i].data, vecs[i].exp, i);

        // Response stall with a second command waiting.
        rsp_ready = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_dir = 1'b0; cmd_count = 3'd1; cmd_data = 8'he5;
        @(posedge clk); #1;
        cmd_dir = 1'b1; cmd_count = 3'd2; cmd_data = 8'h3c;
        wait_rsp(cyc, lp, rp, both);
        check("stall latency", cyc, 32'd3);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("stall%0d rsp_data", k), {24'd0, rsp_data}, 32'h0000_00ca);
            check($sformatf("stall%0d rsp_valid", k), {31'd0, rsp_valid}, 32'd1);
            check($sformatf("stall%0d cmd_ready", k), {31'd0, cmd_ready}, 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        check("stall release rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("stall release cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("stall release latched", {24'd0, sr_parallel_in}, 32'h0000_00e5);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        check("second accepted", {31'd0, busy}, 32'd1);
        wait_rsp(cyc, lp, rp, both);
        check("second latency", cyc, 32'd4);
        check("second rsp_data", {24'd0, rsp_data}, 32'h0000_000f);
        check("second right pulses", rp, 32'd2);
        @(posedge clk); #1;

        // Reset in the middle of a count-7 shift.
        @(negedge clk);
        cmd_valid = 1'b1; cmd_dir = 1'b0; cmd_count = 3'd7; cmd_data = 8'he5;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        check("midshift left", {31'd0, sr_shift_left}, 32'd1);
        reset = 1'b1;
        #1;
        check("midreset cmd_ready", {31'd0, cmd_ready}, 32'd0);
        check("midreset busy", {31'd0, busy}, 32'd0);
        check("midreset outs", {14'd0, sr_shift_left, sr_shift_right, sr_parallel_in, rsp_data}, 32'd0);
        saw_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (rsp_valid) saw_valid = 1'b1;
        end
        reset = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (rsp_valid) saw_valid = 1'b1;
        end
        check("no partial rsp", {31'd0, saw_valid}, 32'd0);
        check("post-reset cmd_ready", {31'd0, cmd_ready}, 32'd1);
        do_cmd(1'b1, 3'd3, 8'h81, 8'h10, 7);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule : tb_shift_sequencer
`default_nettype wire
